pwm_multi_channel_gen: RTL and testbench

//   Parametrised N-channel PWM generator with a shared period counter, per-channel duty registers,
//   and two debounced push-buttons (inc/dec) acting on a selected channel.

---
 rtl/pwm_multi_channel_gen.sv | 135 +++++++++++++
 tb/tb_pwm_multi_channel_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel_gen.sv
// pwm_multi_channel_gen: N-channel PWM with a shared period counter, double-buffered duties and debounced inc/dec buttons.
// Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting with a 2*PERIOD cycle period.
module pwm_multi_channel_gen #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 5,
    parameter int DEB_DIV   = 4,
    parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic [SEL_W-1:0]  ch_sel,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [CNT_W-1:0]  duty_o,
    output logic              period_tick
);
    localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DW-1:0]    DEB_MAX = DW'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] D_INIT  = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W:0]   PER_X   = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X  = (CNT_W+1)'(STEP);

    logic [DW-1:0]     deb_cnt;
    logic              tick, inc_s1, inc_s2, dec_s1, dec_s2, inc_press, dec_press;
    logic [CNT_W-1:0]  cnt, sel_duty, nxt_duty;
    logic [CNT_W:0]    sum;
    logic              sel_ok, upd, wrap;
    logic [NUM_CH-1:0] hit;
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [CNT_W-1:0]  active [NUM_CH];

    assign tick      = deb_cnt == DEB_MAX;
    assign inc_press = inc_s1 & ~inc_s2 & tick;
    assign dec_press = dec_s1 & ~dec_s2 & tick;
    assign upd       = sel_ok & (inc_press ^ dec_press);
    assign duty_o    = sel_duty;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            deb_cnt <= '0;
            inc_s1  <= 1'b0;
            inc_s2  <= 1'b0;
            dec_s1  <= 1'b0;
            dec_s2  <= 1'b0;
        end else begin
            deb_cnt <= tick ? '0 : deb_cnt + DW'(1);
            if (tick) begin
                inc_s1 <= inc_btn;
                inc_s2 <= inc_s1;
                dec_s1 <= dec_btn;
                dec_s2 <= dec_s1;
            end
        end

    // Out-of-range selects match no channel, so presses on them are dropped.
    always_comb begin
        sel_ok   = 1'b0;
        sel_duty = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_sel == SEL_W'(i)) begin
                sel_ok   = 1'b1;
                sel_duty = shadow[i];
            end
        sum      = {1'b0, sel_duty} + STEP_X;
        nxt_duty = inc_press ? ((sum > PER_X) ? PER_X[CNT_W-1:0] : sum[CNT_W-1:0])
                 : (({1'b0, sel_duty} < STEP_X) ? '0 : sel_duty - STEP_X[CNT_W-1:0]);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= D_INIT;
                active[i] <= D_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (upd && ch_sel == SEL_W'(i))
                    shadow[i] <= nxt_duty;
                if (wrap)
                    active[i] <= shadow[i];
            end
        end

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_up;
    assign wrap = !dir_up && cnt == '0;

    // Endpoints are held one extra cycle while the direction flips.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt    <= '0;
            dir_up <= 1'b1;
        end else if (dir_up) begin
            if (cnt == CNT_MAX)
                dir_up <= 1'b0;
            else
                cnt <= cnt + CNT_W'(1);
        end else begin
            if (cnt == '0)
                dir_up <= 1'b1;
            else
                cnt <= cnt - CNT_W'(1);
        end

    always_comb
        for (int i = 0; i < NUM_CH; i++)
            hit[i] = ({1'b0, cnt} + {1'b0, active[i]}) >= PER_X;
`else
    assign wrap = cnt == CNT_MAX;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= wrap ? '0 : cnt + CNT_W'(1);

    always_comb
        for (int i = 0; i < NUM_CH; i++)
            hit[i] = cnt < active[i];
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= hit;
            period_tick <= wrap;
        end
endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// tb_pwm_multi_channel_gen: table-driven press vectors with a queued expectation per vector, plus reset and bounce sequences.
module tb_pwm_multi_channel_gen;
    localparam int NUM_CH  = 4;
    localparam int PERIOD  = 10;
    localparam int DEB_DIV = 4;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int PCYC = 2 * PERIOD;
    localparam int HM   = 2;
`else
    localparam int PCYC = PERIOD;
    localparam int HM   = 1;
`endif

    typedef logic [NUM_CH-1:0][7:0] dvec_t;
    typedef struct { int ch; bit inc; bit dec; int exp; } vec_t;
    typedef struct { int ch; dvec_t duty; } exp_t;

    logic              clk = 1'b0, rst = 1'b1, inc_btn = 1'b0, dec_btn = 1'b0;
    logic [1:0]        ch_sel = 2'd0;
    logic [NUM_CH-1:0] pwm_out;
    logic [7:0]        duty_o;
    logic              period_tick;
    int                checks = 0, errors = 0;
    vec_t              tv[$];
    exp_t              sb[$];

    always #5 clk = ~clk;

    pwm_multi_channel_gen dut (
        .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .ch_sel(ch_sel),
        .pwm_out(pwm_out), .duty_o(duty_o), .period_tick(period_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int ch, input bit inc, input bit dec, input int exp);
        vec_t v;
        v.ch = ch; v.inc = inc; v.dec = dec; v.exp = exp;
        tv.push_back(v);
    endfunction

    task automatic press(input int ch, input bit inc, input bit dec);
        ch_sel = 2'(ch); inc_btn = inc; dec_btn = dec;
        repeat (3 * DEB_DIV) @(negedge clk);
        inc_btn = 1'b0; dec_btn = 1'b0;
        repeat (3 * DEB_DIV) @(negedge clk);
    endtask

    task automatic sync_tick();
        int n = 0;
        while (period_tick !== 1'b1 && n < 4 * PCYC) begin
            @(negedge clk);
            n++;
        end
        chk("tick_sync", int'(period_tick === 1'b1), 1);
    endtask

    task automatic measure(output int hi[NUM_CH], output int ticks);
        for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
        ticks = 0;
        sync_tick();
        for (int k = 0; k < PCYC; k++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
            ticks += int'(period_tick);
        end
    endtask

    task automatic post_reset_check(input string tag);
        int first = 0;
        int h[NUM_CH] = '{default: 0};
        for (int k = 1; k <= PCYC; k++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) h[i] += int'(pwm_out[i]);
            if (period_tick && first == 0) first = k;
        end
        chk({tag, "_first_tick"}, first, PCYC);
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("%s_hi_ch%0d", tag, i), h[i], 5 * HM);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        dvec_t ed;
        exp_t  e;
        int    hi[NUM_CH];
        int    ticks, h0, h1, d;
        for (int i = 0; i < NUM_CH; i++) ed[i] = 8'd5;
        add(0, 0, 0, 5);
        add(2, 1, 0, 6);
        for (int k = 0; k < 7; k++) add(0, 1, 0, (6 + k > 10) ? 10 : 6 + k);
        for (int k = 0; k < 12; k++) add(0, 0, 1, (9 - k < 0) ? 0 : 9 - k);
        add(1, 1, 1, 5);

        #12;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_duty", int'(duty_o), 5);
        @(negedge clk);
        rst = 1'b0;
        post_reset_check("init");

        foreach (tv[j]) begin
            if (tv[j].inc || tv[j].dec)
                press(tv[j].ch, tv[j].inc, tv[j].dec);
            else
                ch_sel = 2'(tv[j].ch);
            ed[tv[j].ch] = 8'(tv[j].exp);
            e.ch = tv[j].ch;
            e.duty = ed;
            sb.push_back(e);
            measure(hi, ticks);
            e = sb.pop_front();
            chk($sformatf("duty_v%0d", j), int'(duty_o), int'(e.duty[e.ch]));
            for (int i = 0; i < NUM_CH; i++)
                chk($sformatf("hi_v%0d_ch%0d", j, i), hi[i], HM * int'(e.duty[i]));
            chk($sformatf("ticks_v%0d", j), ticks, 1);
        end

        ch_sel = 2'd1;
        sync_tick();
        chk("mid_duty_before", int'(duty_o), 5);
        inc_btn = 1'b1;
        h0 = 0; h1 = 0;
        for (int k = 1; k <= 2 * PCYC; k++) begin
            @(negedge clk);
            if (k == 3 * DEB_DIV) inc_btn = 1'b0;
            if (k <= PCYC) h0 += int'(pwm_out[1]); else h1 += int'(pwm_out[1]);
        end
        chk("mid_cur_period", h0, 5 * HM);
        chk("mid_next_period", h1, 6 * HM);
        chk("mid_duty_after", int'(duty_o), 6);
        repeat (3 * DEB_DIV) @(negedge clk);

        ch_sel = 2'd3;
        for (int k = 0; k < DEB_DIV; k++) begin
            inc_btn = (k % 2 == 0);
            @(negedge clk);
        end
        inc_btn = 1'b0;
        repeat (3 * DEB_DIV) @(negedge clk);
        d = int'(duty_o);
        chk("bounce_le_one_press", int'(d == 5 || d == 6), 1);

        ch_sel = 2'd2;
        sync_tick();
        repeat (7) @(negedge clk);
        chk("pre_rst_duty", int'(duty_o), 6);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_tick", int'(period_tick), 0);
        chk("async_rst_duty", int'(duty_o), 5);
        @(negedge clk);
        rst = 1'b0;
        post_reset_check("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
